// File: rtl/alu_operand_mux_rr.sv
// Registered N:1 operand selector (direct select or round-robin) feeding the ALU input stage.
// Latency: 1 cycle from input accept to out_valid; full throughput of 1 transfer per cycle.
// Backpressure: while out_valid && !out_ready the output holds and every in_ready is 0.
// Optional feature macro ALU_MUX_SEL_ERR_EN adds a sticky sel_err output for out-of-range sel.
module alu_operand_mux_rr #(
  parameter int  WIDTH  = 8,
  parameter int  NUM_IN = 3,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
`ifdef ALU_MUX_SEL_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] g;
  logic             grant;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] ch_dat [NUM_IN];

  // Split the flat input bus into per-channel words
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      ch_dat[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The output register can take new data when empty or being drained this cycle
  assign load_en = !out_valid || out_ready;
  assign xfer    = grant && load_en;

  // Grant: direct index in mode 0, first valid channel at or after rr_ptr in mode 1
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] cand;
    grant = 1'b0;
    g     = '0;
    idx   = 0;
    cand  = '0;
    if (!mode) begin
      if (int'(sel) < NUM_IN) begin
        if (in_valid[sel]) begin
          grant = 1'b1;
          g     = sel;
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        cand = SEL_W'(idx);
        if (!grant && in_valid[cand]) begin
          grant = 1'b1;
          g     = cand;
        end
      end
    end
  end

  // One-hot accept to the granted channel; held off entirely while reset is asserted
  always_comb begin
    in_ready = '0;
    if (xfer && rst_n) in_ready[g] = 1'b1;
  end

  // Output register and round-robin pointer; pointer only advances on mode-1 transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_dat[g];
        out_ch    <= g;
        if (mode) begin
          rr_ptr <= (g == SEL_W'(NUM_IN - 1)) ? '0 : g + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_MUX_SEL_ERR_EN
  // Sticky flag: an out-of-range direct select was presented while any input was valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (!mode && (int'(sel) >= NUM_IN) && (|in_valid)) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_mux_rr.sv
// Directed bench for alu_operand_mux_rr (WIDTH=8, NUM_IN=3) with a scoreboard queue.
// Expected operands are pushed when the bench's own grant model predicts an accept.
// They are popped and compared one clock later when the output register should update.
module tb_alu_operand_mux_rr;

  typedef struct packed {
    logic [7:0] dat;
    logic [1:0] ch;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [2:0]  in_valid;
  logic [23:0] in_data;
  logic [2:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
`ifdef ALU_MUX_SEL_ERR_EN
  logic        sel_err;
`endif

  logic [7:0]  d [3];
  exp_t        q [$];

  // bench-side reference state
  logic        m_vld;
  logic [7:0]  m_dat;
  logic [1:0]  m_ch;
  int          m_rr;
  logic        m_err;

  int n_pass;
  int n_fail;
  int n_tot;

  alu_operand_mux_rr #(.WIDTH(8), .NUM_IN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef ALU_MUX_SEL_ERR_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign in_data = {d[2], d[1], d[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    m_dat = 8'h00;
    m_ch  = 2'd0;
    m_rr  = 0;
    m_err = 1'b0;
    q.delete();
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(input string tag);
    int   g;
    bit   gr;
    bit   le;
    bit   xf;
    bit   err_nx;
    exp_t e;
    logic [2:0] rdy_exp;
    g  = 0;
    gr = 1'b0;
    #3;
    le = !m_vld || out_ready;
    if (!mode) begin
      if (sel < 2'd3 && in_valid[sel]) begin
        gr = 1'b1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!gr && in_valid[(m_rr + k) % 3]) begin
          gr = 1'b1;
          g  = (m_rr + k) % 3;
        end
      end
    end
    xf      = gr && le;
    rdy_exp = xf ? (3'b001 << g) : 3'b000;
    check({tag, "/in_ready"}, 32'(in_ready), 32'(rdy_exp));
    if (xf) q.push_back({d[g], 2'(g)});
    err_nx = m_err || (!mode && sel == 2'd3 && in_valid != 3'b000);
    @(posedge clk);
    #1;
    m_err = err_nx;
    if (xf) begin
      e     = q.pop_front();
      m_vld = 1'b1;
      m_dat = e.dat;
      m_ch  = e.ch;
      if (mode) m_rr = (g == 2) ? 0 : g + 1;
      check({tag, "/out_data"}, 32'(out_data), 32'(e.dat));
      check({tag, "/out_ch"}, 32'(out_ch), 32'(e.ch));
    end else begin
      if (out_ready) m_vld = 1'b0;
      if (m_vld) begin
        check({tag, "/hold_data"}, 32'(out_data), 32'(m_dat));
        check({tag, "/hold_ch"}, 32'(out_ch), 32'(m_ch));
      end
    end
    check({tag, "/out_valid"}, 32'(out_valid), 32'(m_vld));
`ifdef ALU_MUX_SEL_ERR_EN
    check({tag, "/sel_err"}, 32'(sel_err), 32'(m_err));
`endif
  endtask

  initial begin
    n_pass = 0;
    n_fail = 0;
    n_tot  = 0;
    model_reset();
    d[0] = 8'd5;
    d[1] = 8'd10;
    d[2] = 8'd15;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 3'b111;
    out_ready = 1'b1;

    // reset state, including no accept while reset is held
    #1;
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/out_data", 32'(out_data), 32'd0);
    check("rst/out_ch", 32'(out_ch), 32'd0);
    check("rst/in_ready", 32'(in_ready), 32'd0);
    in_valid = 3'b000;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 3'b111;

    // 1: direct select 0,1,2
    sel = 2'd0; cycle("dir0");
    sel = 2'd1; cycle("dir1");
    sel = 2'd2; cycle("dir2");

    // 2: round robin over all valid, then over 101
    mode = 1'b1;
    for (int i = 0; i < 6; i++) cycle("rr_all");
    in_valid = 3'b101;
    for (int i = 0; i < 4; i++) cycle("rr_101");

    // 3: backpressure with sel=1
    mode = 1'b0; sel = 2'd1; in_valid = 3'b111;
    cycle("bp_load");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle("bp_hold");
    out_ready = 1'b1;
    cycle("bp_release");

    // 4: out-of-range select drains the output, then sel returns to 0
    sel = 2'd3;
    cycle("oor_drain");
    cycle("oor_idle");
    sel = 2'd0;
    cycle("oor_back");

    // 5: signed extreme value passes bit-exact
    d[1] = 8'h80; sel = 2'd1;
    cycle("signed");
    sel = 2'd0;
    cycle("signed_next");

    // 6: load ch1 in round robin so rr_ptr=2, hold it, then reset between edges
    mode = 1'b1; in_valid = 3'b010;
    cycle("pre_rst_load");
    out_ready = 1'b0;
    cycle("pre_rst_hold");
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/out_data", 32'(out_data), 32'd0);
    check("midrst/out_ch", 32'(out_ch), 32'd0);
    check("midrst/in_ready", 32'(in_ready), 32'd0);
    model_reset();
    rst_n     = 1'b1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    cycle("post_rst_rr");
    cycle("post_rst_rr2");

    check("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
